// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: captures operands on start, processes one bit
// per cycle LSB first, and presents the registered result with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sum_bit;
    logic             carry_nx;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        s_d      = s_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
        carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_nx;
                cnt_d   = cnt_q + CW'(1);
                // Outputs only update with the completed result, never mid-shift
                if (cnt_q == LAST) begin
                    s_d     = {sum_bit, res_q[WIDTH-1:1]};
                    c_d     = carry_nx;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign c    = c_q;

endmodule
